// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and lane packing helpers.
// Lanes alternate re/im: re at even indices, im at odd indices.
package fft_pkg;

  localparam int FFT_W     = 35;
  localparam int FFT_LANES = 8;
  localparam int LANE_RE   = 0;
  localparam int LANE_IM   = 1;

  typedef logic signed [FFT_W-1:0] lane_t;
  typedef logic [FFT_LANES*FFT_W-1:0] beat_t;

  function automatic lane_t lane_get(
    input beat_t b,
    input int    i
  );
    return lane_t'(b[i*FFT_W +: FFT_W]);
  endfunction

  function automatic beat_t lane_set(
    input beat_t b,
    input int    i,
    input lane_t x
  );
    beat_t r;
    r = b;
    r[i*FFT_W +: FFT_W] = x;
    return r;
  endfunction

endpackage

// File: rtl/fft_pipe_slot.sv
// One elastic stage: valid bit plus data word.
// Data only moves when a valid beat loads, keeping empty slots quiet.
module fft_pipe_slot #(
  parameter int DW = 280
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          en,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  output logic          valid,
  output logic [DW-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (flush)
        valid <= 1'b0;
      else if (en)
        valid <= up_valid;
      if (en && up_valid && !flush)
        data <= up_data;
    end
  end

endmodule

// File: rtl/fft_lane_pipe.sv
// Elastic register bank between FFT butterfly stages.
// Bubbles collapse, so DEPTH beats buffer under full backpressure.
module fft_lane_pipe
  import fft_pkg::*;
#(
  parameter int W     = FFT_W,
  parameter int LANES = FFT_LANES,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*W-1:0]         in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*W-1:0]         out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int DW = LANES * W;
  localparam int OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] en;
  logic [DEPTH-1:0] take;
  logic [DEPTH:0]   vc;
  logic [DW-1:0]    dc [DEPTH+1];
  logic             acc;
  logic             dlv;

  assign vc    = {v, in_valid};
  assign dc[0] = in_data;

  // take[k] unrolled from the en chain: any empty stage downstream frees room
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == DEPTH - 1) begin : g_last
      assign take[k] = out_ready;
    end else begin : g_mid
      assign take[k] = out_ready | ~(&v[DEPTH-1:k+1]);
    end

    assign en[k] = ~v[k] | take[k];

    fft_pipe_slot #(
      .DW(DW)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .en       (en[k]),
      .up_valid (vc[k]),
      .up_data  (dc[k]),
      .valid    (v[k]),
      .data     (dc[k+1])
    );
  end

  assign in_ready  = en[0] & ~flush;
  assign out_valid = vc[DEPTH];
  assign out_data  = dc[DEPTH];

  assign acc = in_valid & in_ready;
  assign dlv = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      occupancy <= '0;
    else if (flush)
      occupancy <= '0;
    else
      occupancy <= occupancy + OW'(acc) - OW'(dlv);
  end

endmodule

// File: tb/tb_fft_lane_pipe.sv
// Bench for fft_lane_pipe: directed table, stream, reset and flush cases,
// plus randomized queue-model checks over several DEPTH/LANES/W settings.
module tb_fft_lane_pipe;
  import fft_pkg::*;

  localparam int W  = 35;
  localparam int L  = 8;
  localparam int D  = 2;
  localparam int DW = L * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          rst_s;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fft_lane_pipe #(.W(W), .LANES(L), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  task automatic chk(input string n, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endtask

  // lane0 = -1, lane7 = max positive, middle lanes negative and tag-unique
  function automatic logic [DW-1:0] mk(input int tag);
    beat_t b;
    lane_t x;
    b = '0;
    for (int i = 0; i < L; i++) begin
      if (i == 0) x = -35'sd1;
      else if (i == 7) x = 35'sd17179869183;
      else x = lane_t'(-(tag * 16 + i));
      b = lane_set(b, i, x);
    end
    return b;
  endfunction

  typedef struct {
    logic iv;
    logic ordy;
    logic fl;
    int   tag;
    logic ir;
    logic ov;
    int   otag;
    int   occ;
  } vec_t;

  // parameter sweep: LANES=2, W=16, DEPTH 1/3/4
  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int SD  = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    localparam int SOW = $clog2(SD + 1);
    logic           iv, ordy, ir, ov, fl, act, dn;
    logic [31:0]    id, od;
    logic [SOW-1:0] occ;
    logic [31:0]    q[$];

    fft_lane_pipe #(.W(16), .LANES(2), .DEPTH(SD)) dut_s (
      .clk       (clk),
      .rst       (rst_s),
      .flush     (fl),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_data   (id),
      .out_valid (ov),
      .out_ready (ordy),
      .out_data  (od),
      .occupancy (occ)
    );

    initial begin
      int edges;
      iv = 0; ordy = 1; fl = 0; id = '0; act = 0; dn = 0;
      wait (!rst_s);
      @(posedge clk); #1;
      iv = 1; id = 32'hA5A5_0000 + g; act = 1;
      @(posedge clk); edges = 1; #1;
      iv = 0;
      while (edges < 20) begin
        @(negedge clk);
        if (ov) break;
        @(posedge clk);
        edges++;
      end
      chk($sformatf("sw%0d_latency", SD), edges, SD);
      for (int n = 0; n < 400; n++) begin
        @(posedge clk); #1;
        iv   = $urandom_range(0, 9) < 7;
        ordy = (n % 40 < 8) ? 1'b0 : ($urandom_range(0, 9) < 7);
        fl   = $urandom_range(0, 59) == 0;
        id   = $urandom;
      end
      @(posedge clk); #1;
      act = 0; iv = 0; fl = 0;
      dn = 1;
    end

    always @(negedge clk) begin
      if (act) begin
        chk($sformatf("sw%0d_ready", SD), ir,
            !fl && (q.size() < SD || ordy));
        chk($sformatf("sw%0d_occ", SD), occ, q.size());
        if (ov && ordy) begin
          if (q.size() == 0) chk($sformatf("sw%0d_spurious", SD), ov, 0);
          else chk($sformatf("sw%0d_data", SD), od, q.pop_front());
        end
        if (fl) q.delete();
        if (iv && ir) q.push_back(id);
      end
    end
  end

  initial begin
    vec_t tv[15];
    logic [DW-1:0] q[$];
    int tagc;
    int cnt;

    tv[0]  = '{1, 1, 0, 1, 1, 0, 0, 0};
    tv[1]  = '{1, 1, 0, 2, 1, 0, 0, 1};
    tv[2]  = '{1, 1, 0, 3, 1, 1, 1, 2};
    tv[3]  = '{1, 0, 0, 4, 0, 1, 2, 2};
    tv[4]  = '{1, 0, 0, 4, 0, 1, 2, 2};
    tv[5]  = '{0, 1, 0, 0, 1, 1, 2, 2};
    tv[6]  = '{0, 0, 0, 0, 1, 1, 3, 1};
    tv[7]  = '{1, 0, 0, 5, 1, 1, 3, 1};
    tv[8]  = '{1, 0, 0, 6, 0, 1, 3, 2};
    tv[9]  = '{1, 1, 1, 6, 0, 1, 3, 2};
    tv[10] = '{0, 1, 0, 0, 1, 0, 0, 0};
    tv[11] = '{1, 1, 0, 7, 1, 0, 0, 0};
    tv[12] = '{0, 1, 0, 0, 1, 0, 0, 1};
    tv[13] = '{0, 1, 0, 0, 1, 1, 7, 1};
    tv[14] = '{0, 1, 0, 0, 1, 0, 0, 0};

    rst = 1; rst_s = 1; flush = 0;
    in_valid = 0; out_ready = 1; in_data = '0;
    #12;
    rst = 0; rst_s = 0;
    @(negedge clk);
    chk("reset_ov", out_valid, 0);
    chk("reset_data", out_data, '0);
    chk("reset_occ", occupancy, 0);
    chk("reset_ir", in_ready, 1);

    for (int r = 0; r < 15; r++) begin
      @(posedge clk); #1;
      in_valid  = tv[r].iv;
      out_ready = tv[r].ordy;
      flush     = tv[r].fl;
      in_data   = mk(tv[r].tag);
      @(negedge clk);
      chk($sformatf("tbl%0d_ir", r), in_ready, tv[r].ir);
      chk($sformatf("tbl%0d_ov", r), out_valid, tv[r].ov);
      chk($sformatf("tbl%0d_occ", r), occupancy, tv[r].occ);
      if (tv[r].otag != 0)
        chk($sformatf("tbl%0d_data", r), out_data, mk(tv[r].otag));
    end

    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      in_valid = c < 10; out_ready = 1; flush = 0;
      in_data = mk(20 + c);
      @(negedge clk);
      chk($sformatf("stream%0d_ov", c), out_valid, c >= 2);
      chk($sformatf("stream%0d_occ", c), occupancy,
          (c == 0) ? 0 : (c == 1) ? 1 : (c <= 10) ? 2 : 1);
      if (c >= 2)
        chk($sformatf("stream%0d_data", c), out_data, mk(18 + c));
    end

    @(posedge clk); #1;
    in_valid = 1; in_data = mk(40);
    @(posedge clk); #1;
    in_data = mk(41);
    @(posedge clk); #1;
    in_valid = 0; out_ready = 0;
    chk("midrst_pre_occ", occupancy, 2);
    #2 rst = 1;
    #1;
    chk("midrst_ov", out_valid, 0);
    chk("midrst_data", out_data, '0);
    chk("midrst_occ", occupancy, 0);
    chk("midrst_ir", in_ready, 1);
    @(negedge clk);
    rst = 0;

    tagc = 100;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      in_valid  = $urandom_range(0, 9) < 7;
      out_ready = (n % 50 < 6) ? 1'b0 : ($urandom_range(0, 9) < 6);
      flush     = $urandom_range(0, 49) == 0;
      in_data   = mk(tagc);
      @(negedge clk);
      chk("rnd_ir", in_ready, !flush && (q.size() < D || out_ready));
      chk("rnd_occ", occupancy, q.size());
      if (q.size() == 0) chk("rnd_ov_empty", out_valid, 0);
      if (out_valid && out_ready && q.size() != 0)
        chk("rnd_data", out_data, q.pop_front());
      if (flush) q.delete();
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        tagc++;
      end
    end
    @(posedge clk); #1;
    in_valid = 0; flush = 0;

    cnt = 0;
    while (!(sw[0].dn && sw[1].dn && sw[2].dn) && cnt < 5000) begin
      @(posedge clk);
      cnt++;
    end
    chk("sweep_done", {sw[2].dn, sw[1].dn, sw[0].dn}, 3'b111);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
